opsum_drain_arb: RTL and testbench

Round-robin drain controller for the bank of `opsum_fifo` instances at the PE-array output. It sequences pops from `NUM_CH` opsum FIFOs, using 32-bit burst pops when two partial sums are available and 16-bit pops for an odd tail. It writes each popped word to the GLB through a valid/ready write port, at a per-channel base address plus a running word offset. It sits between the opsum FIFOs and the GLB write arbiter and is started once per tile by the layer controller.

---
 rtl/opsum_drain_pkg.sv | 19 +
 rtl/opsum_drain_arb_rr.sv | 29 ++
 rtl/opsum_drain_arb.sv | 154 +++++++++++++++
 tb/tb_opsum_drain_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opsum_drain_pkg.sv
// Shared types and constants for the opsum drain controller.
package opsum_drain_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_POP,
    S_CAPT,
    S_WRITE,
    S_DONE
  } drain_state_e;

  localparam int PSUM_W = 16;
  localparam int GLB_DW = 32;

  localparam logic [3:0] WSTRB_LO  = 4'b0011;
  localparam logic [3:0] WSTRB_ALL = 4'b1111;

endpackage

// File: rtl/opsum_drain_arb_rr.sv
// Combinational round-robin picker; scans upward from ptr with wrap.
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant_oh,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_vld
);

  always_comb begin
    int c;
    c         = 0;
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (int'(ptr) + i) % NUM_CH;
      if (!grant_vld && req[IDX_W'(c)]) begin
        grant_vld             = 1'b1;
        grant_idx             = IDX_W'(c);
        grant_oh[IDX_W'(c)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/opsum_drain_arb.sv
// Round-robin drain of the opsum FIFO bank into the GLB write port.
module opsum_drain_arb
  import opsum_drain_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_base_addr,
  input  logic [NUM_CH-1:0]        fifo_empty,
  input  logic [NUM_CH-1:0]        fifo_ge2,
  output logic [NUM_CH-1:0]        fifo_pop_en,
  output logic                     fifo_pop_mod,
  input  logic [NUM_CH*32-1:0]     fifo_pop_data,
  output logic                     glb_we,
  input  logic                     glb_ready,
  output logic [ADDR_W-1:0]        glb_addr,
  output logic [31:0]              glb_wdata,
  output logic [3:0]               glb_wstrb,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  drain_state_e state, state_nxt;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant;
  logic [NUM_CH-1:0] grant_oh;
  logic              mode;
  logic [LEN_W-1:0]  remain [NUM_CH];
  logic [ADDR_W-1:0] off    [NUM_CH];
  logic [ADDR_W-1:0] base   [NUM_CH];

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] arb_oh;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_vld;
  logic [LEN_W-1:0]  rem_nxt;
  logic              last;
  logic [GLB_DW-1:0] slice;

  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = (remain[c] >= LEN_W'(2) && fifo_ge2[c]) ||
                (remain[c] == LEN_W'(1) && !fifo_empty[c]);
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req       (elig),
    .ptr       (rr_ptr),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  assign rem_nxt = remain[grant] - (mode ? LEN_W'(2) : LEN_W'(1));
  assign slice   = fifo_pop_data[int'(grant)*GLB_DW +: GLB_DW];

  // Drain is complete when the granted channel's post-write count and all others are zero.
  always_comb begin
    last = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (IDX_W'(c) == grant) begin
        if (rem_nxt != '0) last = 1'b0;
      end else if (remain[c] != '0) begin
        last = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (cfg_start)
                 state_nxt = (cfg_len == '0) ? S_DONE : S_ARB;
      S_ARB:   if (arb_vld) state_nxt = S_POP;
      S_POP:   state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_WRITE;
      S_WRITE: if (glb_ready)
                 state_nxt = last ? S_DONE : S_ARB;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant     <= '0;
      grant_oh  <= '0;
      mode      <= 1'b0;
      glb_addr  <= '0;
      glb_wdata <= '0;
      glb_wstrb <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        remain[c] <= '0;
        off[c]    <= '0;
        base[c]   <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: if (cfg_start) begin
          rr_ptr <= '0;
          for (int c = 0; c < NUM_CH; c++) begin
            remain[c] <= cfg_len;
            off[c]    <= '0;
            base[c]   <= cfg_base_addr[c*ADDR_W +: ADDR_W];
          end
        end
        S_ARB: if (arb_vld) begin
          grant    <= arb_idx;
          grant_oh <= arb_oh;
          mode     <= (remain[arb_idx] >= LEN_W'(2));
        end
        S_CAPT: begin
          glb_addr <= base[grant] + off[grant];
          if (mode) begin
            glb_wdata <= slice;
            glb_wstrb <= WSTRB_ALL;
          end else begin
            glb_wdata <= {{(GLB_DW-PSUM_W){1'b0}}, slice[PSUM_W-1:0]};
            glb_wstrb <= WSTRB_LO;
          end
        end
        S_WRITE: if (glb_ready) begin
          remain[grant] <= rem_nxt;
          off[grant]    <= off[grant] + 1'b1;
          rr_ptr        <= (grant == IDX_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign glb_we       = (state == S_WRITE);
  assign fifo_pop_en  = (state == S_POP) ? grant_oh : '0;
  assign fifo_pop_mod = (state == S_POP) && mode;

endmodule

// File: tb/tb_opsum_drain_arb.sv
// Directed bench for opsum_drain_arb with a queue-level FIFO/GLB model.
module tb_opsum_drain_arb;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int LW = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_start = 1'b0;
  logic [LW-1:0]   cfg_len = '0;
  logic [N*AW-1:0] cfg_base_addr = '0;
  logic [N-1:0]    fifo_empty, fifo_ge2, fifo_pop_en;
  logic            fifo_pop_mod;
  logic [N*32-1:0] fifo_pop_data;
  logic            glb_we;
  logic            glb_ready = 1'b0;
  logic [AW-1:0]   glb_addr;
  logic [31:0]     glb_wdata;
  logic [3:0]      glb_wstrb;
  logic            busy, done;

  opsum_drain_arb #(.NUM_CH(N), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_base_addr(cfg_base_addr), .fifo_empty(fifo_empty),
    .fifo_ge2(fifo_ge2), .fifo_pop_en(fifo_pop_en),
    .fifo_pop_mod(fifo_pop_mod), .fifo_pop_data(fifo_pop_data),
    .glb_we(glb_we), .glb_ready(glb_ready), .glb_addr(glb_addr),
    .glb_wdata(glb_wdata), .glb_wstrb(glb_wstrb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // FIFO bank model: psum streams per channel, one-cycle pop latency.
  logic [15:0] mem [N][256];
  int wr [N] = '{default: 0};
  int rd [N] = '{default: 0};

  always_comb begin
    fifo_empty = '0;
    fifo_ge2   = '0;
    for (int c = 0; c < N; c++) begin
      fifo_empty[c] = (wr[c] == rd[c]);
      fifo_ge2[c]   = (wr[c] - rd[c]) >= 2;
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (fifo_pop_en[c]) begin
        if (fifo_pop_mod) begin
          fifo_pop_data[c*32 +: 32] <= {mem[c][(rd[c]+1)%256], mem[c][rd[c]%256]};
          rd[c] <= rd[c] + 2;
        end else begin
          fifo_pop_data[c*32 +: 32] <= {16'hDEAD, mem[c][rd[c]%256]};
          rd[c] <= rd[c] + 1;
        end
      end
    end
  end

  task automatic push(int c, logic [15:0] v);
    mem[c][wr[c]%256] = v;
    wr[c] = wr[c] + 1;
  endtask

  // Behavioural model of what the GLB must receive.
  int            mrem [N];
  logic [AW-1:0] mbase [N];
  logic [AW-1:0] moff [N];
  int            cons [N];
  int            last_ch = 0;
  bit            mbusy = 0, done_pend = 0, hold = 0, new_done;
  logic [AW-1:0] p_addr;
  logic [31:0]   p_data, e_data;
  logic [3:0]    p_strb, e_strb;
  int            pop_log [$];
  int            w_ch [$];
  logic [AW-1:0] w_addr [$];
  logic [31:0]   w_data [$];
  logic [3:0]    w_strb [$];

  always @(negedge clk) begin
    if (rst) begin
      mbusy = 0; done_pend = 0; hold = 0;
    end else begin
      chk("busy", busy, mbusy);
      chk("done", done, done_pend);
      new_done = 0;
      if (fifo_pop_en != '0) begin
        int ch;
        ch = 0;
        for (int c = 0; c < N; c++) if (fifo_pop_en[c]) ch = c;
        chk("pop_onehot", $countones(fifo_pop_en), 1);
        chk("pop_mod", fifo_pop_mod, mrem[ch] >= 2);
        chk("pop_avail", (wr[ch] - rd[ch]) >= (fifo_pop_mod ? 2 : 1), 1);
        chk("pop_during_we", glb_we, 0);
        last_ch = ch;
        pop_log.push_back(ch);
      end
      if (glb_we) begin
        if (hold) begin
          chk("hold_addr", glb_addr, p_addr);
          chk("hold_data", glb_wdata, p_data);
          chk("hold_strb", glb_wstrb, p_strb);
        end
        if (glb_ready) begin
          int ch, i;
          ch = last_ch;
          i  = cons[ch];
          if (mrem[ch] >= 2) begin
            e_data = {mem[ch][(i+1)%256], mem[ch][i%256]};
            e_strb = 4'hF;
            cons[ch] += 2; mrem[ch] -= 2;
          end else begin
            e_data = {16'h0000, mem[ch][i%256]};
            e_strb = 4'h3;
            cons[ch] += 1; mrem[ch] -= 1;
          end
          chk("wr_addr", glb_addr, mbase[ch] + moff[ch]);
          chk("wr_data", glb_wdata, e_data);
          chk("wr_strb", glb_wstrb, e_strb);
          moff[ch] = moff[ch] + 1'b1;
          w_ch.push_back(ch);
          w_addr.push_back(glb_addr);
          w_data.push_back(glb_wdata);
          w_strb.push_back(glb_wstrb);
          new_done = 1;
          for (int c = 0; c < N; c++) if (mrem[c] != 0) new_done = 0;
        end
        hold   = !glb_ready;
        p_addr = glb_addr;
        p_data = glb_wdata;
        p_strb = glb_wstrb;
      end else begin
        if (hold) chk("we_dropped", glb_we, 1);
        hold = 0;
      end
      if (cfg_start && !mbusy) begin
        mbusy = 1;
        for (int c = 0; c < N; c++) begin
          mrem[c]  = int'(cfg_len);
          mbase[c] = cfg_base_addr[c*AW +: AW];
          moff[c]  = '0;
          cons[c]  = rd[c];
        end
        if (cfg_len == '0) new_done = 1;
      end
      if (done_pend) mbusy = 0;
      done_pend = new_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(int len, logic [N*AW-1:0] b);
    cfg_len       = LW'(len);
    cfg_base_addr = b;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic clear_logs();
    pop_log.delete(); w_ch.delete();
    w_addr.delete(); w_data.delete(); w_strb.delete();
  endtask

  task automatic wait_done(string nm);
    int k;
    k = 0;
    while (!done && k < 300) begin tick(); k++; end
    chk(nm, k < 300, 1);
    if (k >= 300) begin rst = 1'b1; tick(); rst = 1'b0; end
    else tick();
  endtask

  task automatic wait_writes(int n, string nm);
    int k;
    k = 0;
    while (w_ch.size() < n && k < 200) begin tick(); k++; end
    chk(nm, w_ch.size() >= n, 1);
  endtask

  task automatic wait_we(string nm);
    int k;
    k = 0;
    while (!glb_we && k < 200) begin tick(); k++; end
    chk(nm, glb_we, 1);
  endtask

  localparam logic [N*AW-1:0] BASES = {16'h0400, 16'h0300, 16'h0200, 16'h0100};

  initial begin
    tick(); tick();
    chk("rst_pop_en", fifo_pop_en, 0);
    chk("rst_pop_mod", fifo_pop_mod, 0);
    chk("rst_we", glb_we, 0);
    chk("rst_addr", glb_addr, 0);
    chk("rst_wdata", glb_wdata, 0);
    chk("rst_wstrb", glb_wstrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    glb_ready = 1'b1;
    tick();

    // 1: only FIFO0 loaded; it gets both grants via wrap.
    clear_logs();
    for (int k = 1; k <= 4; k++) push(0, 16'(k));
    start(4, BASES);
    wait_writes(2, "t1_writes");
    chk("t1_a0", w_addr[0], 16'h0100);
    chk("t1_d0", w_data[0], 32'h0002_0001);
    chk("t1_s0", w_strb[0], 4'hF);
    chk("t1_a1", w_addr[1], 16'h0101);
    chk("t1_d1", w_data[1], 32'h0004_0003);
    chk("t1_ch1", pop_log[1], 0);
    for (int c = 1; c < N; c++)
      for (int k = 1; k <= 4; k++) push(c, 16'(c*16'h1000 + k));
    wait_done("t1_done");
    chk("t1_count", w_ch.size(), 8);

    // 2: odd length, all loaded.
    clear_logs();
    for (int c = 0; c < N; c++)
      for (int k = 1; k <= 3; k++) push(c, 16'(16'hA000 + c*16'h0100 + k));
    start(3, BASES);
    wait_done("t2_done");
    chk("t2_count", w_ch.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_order", w_ch[i], i % 4);
    chk("t2_d0", w_data[0], 32'hA002_A001);
    chk("t2_d4", w_data[4], 32'h0000_A003);
    chk("t2_s4", w_strb[4], 4'h3);
    chk("t2_a7", w_addr[7], 16'h0401);

    // 3: starvation, only FIFO2 at first.
    clear_logs();
    push(2, 16'hC001); push(2, 16'hC002);
    start(2, BASES);
    wait_writes(1, "t3_first");
    repeat (10) tick();
    chk("t3_no_pop", pop_log.size(), 1);
    chk("t3_busy", busy, 1);
    push(0, 16'hB001); push(0, 16'hB002);
    wait_writes(2, "t3_second");
    push(1, 16'hB101); push(1, 16'hB102);
    push(3, 16'hB301); push(3, 16'hB302);
    wait_done("t3_done");
    chk("t3_g0", w_ch[0], 2);
    chk("t3_g1", w_ch[1], 0);
    chk("t3_g2", w_ch[2], 1);
    chk("t3_g3", w_ch[3], 3);
    chk("t3_a0", w_addr[0], 16'h0300);
    chk("t3_d1", w_data[1], 32'hB002_B001);

    // 4: backpressure.
    clear_logs();
    for (int c = 0; c < N; c++) begin
      push(c, 16'(16'hD001 + c*16'h10)); push(c, 16'(16'hD002 + c*16'h10));
    end
    glb_ready = 1'b0;
    start(2, BASES);
    wait_we("t4_we");
    repeat (5) tick();
    chk("t4_we_held", glb_we, 1);
    chk("t4_one_pop", pop_log.size(), 1);
    chk("t4_no_write", w_ch.size(), 0);
    glb_ready = 1'b1;
    wait_done("t4_done");
    chk("t4_count", w_ch.size(), 4);
    chk("t4_d0", w_data[0], 32'hD002_D001);

    // 5: zero length, then restart attempt during ARB.
    clear_logs();
    start(0, BASES);
    chk("t5_done", done, 1);
    tick();
    chk("t5_idle", busy, 0);
    chk("t5_no_pop", pop_log.size(), 0);
    start(2, BASES);
    tick(); tick();
    start(6, {16'h0900, 16'h0900, 16'h0900, 16'h0900});
    for (int c = 0; c < N; c++) begin
      push(c, 16'(16'hF001 + c)); push(c, 16'(16'hF101 + c));
    end
    wait_done("t5_done2");
    chk("t5_count", w_ch.size(), 4);
    chk("t5_a0", w_addr[0], 16'h0100);

    // 6: reset during WRITE.
    clear_logs();
    for (int c = 0; c < N; c++)
      for (int k = 1; k <= 4; k++) push(c, 16'(16'hE000 + c*16'h0100 + k));
    glb_ready = 1'b0;
    start(4, BASES);
    wait_we("t6_we");
    rst = 1'b1;
    #1;
    chk("t6_we", glb_we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_addr", glb_addr, 0);
    chk("t6_wdata", glb_wdata, 0);
    chk("t6_wstrb", glb_wstrb, 0);
    chk("t6_pop", fifo_pop_en, 0);
    tick();
    rst = 1'b0;
    glb_ready = 1'b1;
    clear_logs();
    start(2, {16'h0800, 16'h0700, 16'h0600, 16'h0500});
    wait_done("t6_done");
    chk("t6_ch0", w_ch[0], 0);
    chk("t6_a0", w_addr[0], 16'h0500);
    chk("t6_d0", w_data[0], 32'hE004_E003);
    chk("t6_a1", w_addr[1], 16'h0600);
    chk("t6_d1", w_data[1], 32'hE102_E101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
